// File: rtl/alu_seq_param.sv
// Sequential unsigned ALU: single-cycle add/sub/logic ops, iterative shift-add multiply
// and restoring divide (one step per clock), with done/busy/err handshake.
module alu_seq_param #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W-1:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [2:0]     op_reg;
    logic [2*W-1:0] a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc;

    logic [W:0]     sum_ext;
    logic [W:0]     diff_ext;
    logic [2*W-1:0] single_res;
    logic           single_err;
    logic           multi_cycle;

    logic [W:0]     div_trial;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic [2*W-1:0] acc_step;

    assign busy = (state == EXEC);
    assign done = (state == DONE);

    // Result of every operation that completes on the accepting edge; MUL by zero lands here too.
    always_comb begin
        sum_ext     = {1'b0, in_a} + {1'b0, in_b};
        diff_ext    = {1'b0, in_a} - {1'b0, in_b};
        single_res  = '0;
        single_err  = 1'b0;
        multi_cycle = ((op == OP_MUL) || (op == OP_DIV)) && (in_b != '0);
        case (op)
            OP_ADD:  single_res = {{(W-1){1'b0}}, sum_ext};
            OP_SUB:  single_res = {{(W-1){1'b0}}, diff_ext};
            OP_MUL:  single_res = '0;
            OP_DIV: begin
                single_res = {in_a, {W{1'b1}}};
                single_err = 1'b1;
            end
            OP_AND:  single_res = {{W{1'b0}}, in_a & in_b};
            OP_OR:   single_res = {{W{1'b0}}, in_a | in_b};
            OP_XOR:  single_res = {{W{1'b0}}, in_a ^ in_b};
            default: single_err = 1'b1;
        endcase
    end

    // For DIV, acc holds {remainder, dividend/quotient}; quotient bits shift in from the bottom.
    always_comb begin
        div_trial = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_trial - {1'b0, b_reg};
        div_ge    = (div_trial >= {1'b0, b_reg});
        if (op_reg == OP_DIV)
            acc_step = {(div_ge ? div_diff[W-1:0] : div_trial[W-1:0]), acc[W-2:0], div_ge};
        else
            acc_step = b_reg[0] ? (acc + a_reg) : acc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg <= op;
                        a_reg  <= {{W{1'b0}}, in_a};
                        b_reg  <= in_b;
                        cnt    <= '0;
                        if (multi_cycle) begin
                            acc   <= (op == OP_DIV) ? {{W{1'b0}}, in_a} : '0;
                            state <= EXEC;
                        end else begin
                            result <= single_res;
                            err    <= single_err;
                            state  <= DONE;
                        end
                    end
                end
                EXEC: begin
                    acc   <= acc_step;
                    a_reg <= a_reg << 1;
                    b_reg <= (op_reg == OP_MUL) ? (b_reg >> 1) : b_reg;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        result <= acc_step;
                        err    <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed and random operations against an
// arithmetic reference model, plus reset-abort and a W=16 multiply.
module tb_alu_seq_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        busy, done, err;
    logic [15:0] result;

    logic        start16 = 1'b0;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, err16;
    logic [31:0] result16;

    int tests = 0;
    int failed = 0;
    logic [15:0] last_res;
    logic        last_err;

    always #5 clk = ~clk;

    alu_seq_param #(.W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    alu_seq_param #(.W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .in_a(a16), .in_b(b16),
        .busy(busy16), .done(done16), .err(err16), .result(result16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic void model(input logic [2:0] m_op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output logic e, output int lat);
        int ai = int'(a);
        int bi = int'(b);
        int v = 0;
        e = 1'b0;
        lat = 1;
        case (m_op)
            3'd0: v = ai + bi;
            3'd1: v = ((ai - bi) & 255) + ((ai < bi) ? 256 : 0);
            3'd2: begin
                v = ai * bi;
                if (bi != 0) lat = 9;
            end
            3'd3: begin
                if (bi == 0) begin
                    v = ai * 256 + 255;
                    e = 1'b1;
                end else begin
                    v = (ai % bi) * 256 + ai / bi;
                    lat = 9;
                end
            end
            3'd4: v = ai & bi;
            3'd5: v = ai | bi;
            3'd6: v = ai ^ bi;
            default: begin
                v = 0;
                e = 1'b1;
            end
        endcase
        r = 16'(v);
    endfunction

    task automatic applyStimulus(input logic [2:0] s_op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        int          busy_cycles;
        model(s_op, a, b, exp_res, exp_err, exp_lat);
        @(negedge clk);
        op = s_op; in_a = a; in_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        busy_cycles = 0;
        // Scrambled inputs and stray start pulses after accept must not disturb the operation.
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            start = 1'($urandom_range(0, 1));
            op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("busy_cycles", 32'(busy_cycles), 32'(exp_lat - 1));
        checkOutput("busy_low_in_done", 32'(busy), 32'd0);
        checkOutput("result", 32'(result), 32'(exp_res));
        checkOutput("err", 32'(err), 32'(exp_err));
        last_res = result;
        last_err = err;
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("no_restart", 32'(busy), 32'd0);
        checkOutput("result_held", 32'(result), 32'(exp_res));
    endtask

    initial begin
        int seen;
        int lat;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        applyStimulus(3'd0, 8'd25, 8'd17);
        checkOutput("add_25_17", 32'(last_res), 32'd42);
        applyStimulus(3'd0, 8'd200, 8'd100);
        checkOutput("add_carry", 32'(last_res), 32'h012C);
        applyStimulus(3'd1, 8'd42, 8'd15);
        checkOutput("sub_42_15", 32'(last_res), 32'd27);
        applyStimulus(3'd1, 8'd15, 8'd42);
        checkOutput("sub_borrow", 32'(last_res), 32'h01E5);
        applyStimulus(3'd2, 8'd200, 8'd250);
        checkOutput("mul_200_250", 32'(last_res), 32'd50000);
        applyStimulus(3'd3, 8'd100, 8'd7);
        checkOutput("div_100_7", 32'(last_res), 32'h020E);
        applyStimulus(3'd3, 8'd10, 8'd0);
        checkOutput("div_by_zero", 32'(last_res), 32'h0AFF);
        checkOutput("div_by_zero_err", 32'(last_err), 32'd1);
        applyStimulus(3'd7, 8'd55, 8'd66);
        checkOutput("reserved_op", 32'(last_res), 32'd0);
        applyStimulus(3'd4, 8'hAA, 8'hCC);
        checkOutput("and_aa_cc", 32'(last_res), 32'h0088);
        applyStimulus(3'd5, 8'hAA, 8'hCC);
        checkOutput("or_aa_cc", 32'(last_res), 32'h00EE);
        applyStimulus(3'd6, 8'hAA, 8'hCC);
        checkOutput("xor_aa_cc", 32'(last_res), 32'h0066);
        applyStimulus(3'd2, 8'hFF, 8'hFF);
        applyStimulus(3'd3, 8'hFF, 8'd1);
        applyStimulus(3'd3, 8'd3, 8'hFF);
        applyStimulus(3'd2, 8'd77, 8'd0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus(3'($urandom), 8'($urandom), rb);
        end

        // Reset dropped in the middle of a multiply aborts it without a done pulse.
        @(negedge clk);
        op = 3'd2; in_a = 8'd200; in_b = 8'd250; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checkOutput("no_done_after_abort", 32'(seen), 32'd0);

        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        applyStimulus(3'd0, 8'd1, 8'd1);
        checkOutput("add_after_reset", 32'(last_res), 32'd2);

        @(negedge clk);
        op16 = 3'd2; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        a16 = 16'h1234; b16 = 16'h0001;
        lat = 1;
        while (!done16 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("w16_mul_done", 32'(done16), 32'd1);
        checkOutput("w16_mul_latency", 32'(lat), 32'd17);
        checkOutput("w16_mul_result", result16, 32'hFFFE0001);
        checkOutput("w16_mul_err", 32'(err16), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
